// File: rtl/axicb_mst_if.sv
// Crossbar master ingress: AW/AR request FIFOs with ID masking and W/B/R pass-through.
// Define AXICB_OSTD_LIMIT_EN to throttle requests on outstanding write/read counts.

module axicb_mst_if_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] data_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge aclk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

endmodule

module axicb_mst_if #(
  parameter int AXI_ID_W        = 8,
  parameter int MST_ID_MASK     = 'h00,
  parameter int FIFO_DEPTH      = 4,
  parameter int MST_OSTDREQ_NUM = 4,
  parameter int AWCH_W          = 8,
  parameter int WCH_W           = 8,
  parameter int BCH_W           = 8,
  parameter int ARCH_W          = 8,
  parameter int RCH_W           = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  // master side
  input  logic              i_awvalid,
  output logic              i_awready,
  input  logic [AWCH_W-1:0] i_awch,
  input  logic              i_wvalid,
  output logic              i_wready,
  input  logic              i_wlast,
  input  logic [WCH_W-1:0]  i_wch,
  output logic              i_bvalid,
  input  logic              i_bready,
  output logic [BCH_W-1:0]  i_bch,
  input  logic              i_arvalid,
  output logic              i_arready,
  input  logic [ARCH_W-1:0] i_arch,
  output logic              i_rvalid,
  input  logic              i_rready,
  output logic              i_rlast,
  output logic [RCH_W-1:0]  i_rch,
  // switch side
  output logic              o_awvalid,
  input  logic              o_awready,
  output logic [AWCH_W-1:0] o_awch,
  output logic              o_wvalid,
  input  logic              o_wready,
  output logic              o_wlast,
  output logic [WCH_W-1:0]  o_wch,
  input  logic              o_bvalid,
  output logic              o_bready,
  input  logic [BCH_W-1:0]  o_bch,
  output logic              o_arvalid,
  input  logic              o_arready,
  output logic [ARCH_W-1:0] o_arch,
  input  logic              o_rvalid,
  output logic              o_rready,
  input  logic              o_rlast,
  input  logic [RCH_W-1:0]  o_rch
);

  // Mask zero-extended to full channel width so only ID bits can be set.
  localparam logic [AXI_ID_W-1:0] ID_MASK = AXI_ID_W'(MST_ID_MASK);
  localparam logic [AWCH_W-1:0]   AW_OR   = AWCH_W'(ID_MASK);
  localparam logic [ARCH_W-1:0]   AR_OR   = ARCH_W'(ID_MASK);

  logic              aw_full, aw_empty, aw_push, aw_pop;
  logic              ar_full, ar_empty, ar_push, ar_pop;
  logic [AWCH_W-1:0] aw_head;
  logic [ARCH_W-1:0] ar_head;
  logic              wr_limit, rd_limit;
  logic              b_hs, r_last_hs;

  assign aw_push   = i_awvalid & i_awready;
  assign aw_pop    = o_awvalid & o_awready;
  assign ar_push   = i_arvalid & i_arready;
  assign ar_pop    = o_arvalid & o_arready;
  assign b_hs      = i_bvalid & i_bready;
  assign r_last_hs = i_rvalid & i_rready & i_rlast;

  // Ready looks only at local state, never at o_*ready.
  assign i_awready = !aw_full & !wr_limit;
  assign i_arready = !ar_full & !rd_limit;
  assign o_awvalid = !aw_empty;
  assign o_arvalid = !ar_empty;
  assign o_awch    = aw_head | AW_OR;
  assign o_arch    = ar_head | AR_OR;

  axicb_mst_if_fifo #(.DEPTH(FIFO_DEPTH), .W(AWCH_W)) u_aw_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (aw_push),
    .data_i  (i_awch),
    .pop_i   (aw_pop),
    .full_o  (aw_full),
    .empty_o (aw_empty),
    .data_o  (aw_head)
  );

  axicb_mst_if_fifo #(.DEPTH(FIFO_DEPTH), .W(ARCH_W)) u_ar_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (ar_push),
    .data_i  (i_arch),
    .pop_i   (ar_pop),
    .full_o  (ar_full),
    .empty_o (ar_empty),
    .data_o  (ar_head)
  );

  assign o_wvalid = i_wvalid;
  assign i_wready = o_wready;
  assign o_wlast  = i_wlast;
  assign o_wch    = i_wch;
  assign i_bvalid = o_bvalid;
  assign o_bready = i_bready;
  assign i_bch    = o_bch;
  assign i_rvalid = o_rvalid;
  assign o_rready = i_rready;
  assign i_rlast  = o_rlast;
  assign i_rch    = o_rch;

`ifdef AXICB_OSTD_LIMIT_EN
  localparam int              CNT_W   = $clog2(MST_OSTDREQ_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MST_OSTDREQ_NUM);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // A completion without a matching request is dropped rather than wrapping.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = cnt;
    if (inc && !dec)                    r = cnt + CNT_W'(1);
    else if (dec && !inc && cnt != '0)  r = cnt - CNT_W'(1);
    return r;
  endfunction

  assign wr_cnt_d = cnt_next(wr_cnt_q, aw_push, b_hs);
  assign rd_cnt_d = cnt_next(rd_cnt_q, ar_push, r_last_hs);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_limit = (wr_cnt_q == CNT_MAX);
  assign rd_limit = (rd_cnt_q == CNT_MAX);
`else
  logic unused_hs;
  assign unused_hs = b_hs ^ r_last_hs;
  assign wr_limit  = 1'b0;
  assign rd_limit  = 1'b0;
`endif

endmodule

// File: tb/tb_axicb_mst_if.sv
// Bench for axicb_mst_if: queue/counter reference model checked every cycle plus directed literals.
module tb_axicb_mst_if;

`ifdef AXICB_OSTD_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int NUM   = 2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        i_awvalid, i_awready, o_awvalid, o_awready;
  logic [15:0] i_awch, o_awch;
  logic        i_wvalid, i_wready, i_wlast, o_wvalid, o_wready, o_wlast;
  logic [7:0]  i_wch, o_wch;
  logic        i_bvalid, i_bready, o_bvalid, o_bready;
  logic [7:0]  i_bch, o_bch;
  logic        i_arvalid, i_arready, o_arvalid, o_arready;
  logic [15:0] i_arch, o_arch;
  logic        i_rvalid, i_rready, i_rlast, o_rvalid, o_rready, o_rlast;
  logic [7:0]  i_rch, o_rch;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axicb_mst_if #(
    .AXI_ID_W(8), .MST_ID_MASK('h10), .FIFO_DEPTH(DEPTH), .MST_OSTDREQ_NUM(NUM),
    .AWCH_W(16), .WCH_W(8), .BCH_W(8), .ARCH_W(16), .RCH_W(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_arch(i_arch),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast), .i_rch(i_rch),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: request queues hold the expected switch-side payload.
  logic [15:0] awq[$];
  logic [15:0] arq[$];
  int wcnt = 0;
  int rcnt = 0;

  function automatic bit m_awready();
    return (awq.size() < DEPTH) && !(LIM && wcnt == NUM);
  endfunction
  function automatic bit m_arready();
    return (arq.size() < DEPTH) && !(LIM && rcnt == NUM);
  endfunction

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awq.delete();
      arq.delete();
      wcnt = 0;
      rcnt = 0;
    end else begin : upd
      bit awp, arp, bh, rh;
      awp = i_awvalid && m_awready();
      arp = i_arvalid && m_arready();
      bh  = o_bvalid && i_bready;
      rh  = o_rvalid && i_rready && o_rlast;
      if (awq.size() > 0 && o_awready) void'(awq.pop_front());
      if (arq.size() > 0 && o_arready) void'(arq.pop_front());
      if (awp) awq.push_back(i_awch | 16'h0010);
      if (arp) arq.push_back(i_arch | 16'h0010);
      if (awp && !bh) wcnt++;
      else if (!awp && bh && wcnt > 0) wcnt--;
      if (arp && !rh) rcnt++;
      else if (!arp && rh && rcnt > 0) rcnt--;
    end
  end

  always @(negedge aclk) begin
    chk("m_awready", i_awready, m_awready());
    chk("m_awvalid", o_awvalid, awq.size() > 0);
    if (awq.size() > 0) chk("m_awch", o_awch, awq[0]);
    chk("m_arready", i_arready, m_arready());
    chk("m_arvalid", o_arvalid, arq.size() > 0);
    if (arq.size() > 0) chk("m_arch", o_arch, arq[0]);
    chk("pt_w", {o_wvalid, o_wlast, o_wch, i_wready}, {i_wvalid, i_wlast, i_wch, o_wready});
    chk("pt_b", {i_bvalid, i_bch, o_bready}, {o_bvalid, o_bch, i_bready});
    chk("pt_r", {i_rvalid, i_rlast, i_rch, o_rready}, {o_rvalid, o_rlast, o_rch, i_rready});
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic b_set(input logic v);
    o_bvalid = v;
    i_bready = v;
  endtask

  initial begin
    aresetn = 1'b0;
    {i_awvalid, o_awready, i_arvalid, o_arready} = '0;
    {i_wvalid, i_wlast, o_wready, o_bvalid, i_bready, o_rvalid, o_rlast, i_rready} = '0;
    i_awch = '0; i_arch = '0; i_wch = '0; o_bch = '0; o_rch = '0;
    repeat (3) cyc();
    aresetn = 1'b1;
    cyc();
    chk("rst_awvalid", o_awvalid, 0);
    chk("rst_arvalid", o_arvalid, 0);
    chk("rst_awready", i_awready, 1);
    chk("rst_arready", i_arready, 1);

    // ID masking, one-cycle latency
    i_awvalid = 1'b1; i_awch = 16'hAB03;
    cyc();
    i_awvalid = 1'b0;
    chk("mask_valid", o_awvalid, 1);
    chk("mask_awch", o_awch, 16'hAB13);
    o_awready = 1'b1;
    cyc();
    o_awready = 1'b0;
    chk("mask_popped", o_awvalid, 0);
    b_set(1'b1);
    cyc();

    // FIFO backpressure; B held active so each push pairs with a B
    for (int k = 1; k <= 4; k++) begin
      i_awvalid = 1'b1; i_awch = 16'h5500 | 16'(k);
      cyc();
    end
    i_awvalid = 1'b0;
    chk("full_awready", i_awready, 0);
    chk("full_head", o_awch, 16'h5511);
    o_awready = 1'b1;
    cyc();
    chk("pop1_awready", i_awready, 1);
    chk("pop1_head", o_awch, 16'h5512);
    cyc();
    chk("pop2_head", o_awch, 16'h5513);
    cyc();
    chk("pop3_head", o_awch, 16'h5514);
    cyc();
    chk("drained", o_awvalid, 0);
    b_set(1'b0);

`ifdef AXICB_OSTD_LIMIT_EN
    i_awvalid = 1'b1; i_awch = 16'h0021;
    cyc();
    i_awch = 16'h0022;
    cyc();
    chk("wr_limit", i_awready, 0);
    cyc(); cyc();
    chk("wr_limit_hold", i_awready, 0);
    b_set(1'b1);
    cyc();
    chk("wr_ready_after_b", i_awready, 1);
    cyc();
    b_set(1'b0);
    chk("simul_cnt_one", i_awready, 1);
    cyc();
    i_awvalid = 1'b0;
    chk("simul_then_limit", i_awready, 0);
    b_set(1'b1);
    cyc(); cyc();
    b_set(1'b0);
    chk("wr_cleared", i_awready, 1);
`else
    for (int k = 0; k < 8; k++) begin
      i_awvalid = 1'b1; i_awch = 16'h0060 + 16'(k);
      cyc();
      chk("nolimit_awready", i_awready, 1);
    end
    i_awvalid = 1'b0;
`endif
    o_awready = 1'b1;
    cyc();

    // Read limit across a 4-beat burst
    o_arready = 1'b1;
    i_arvalid = 1'b1; i_arch = 16'h0031;
    cyc();
    i_arch = 16'h0032;
    cyc();
    i_arvalid = 1'b0;
    chk("rd_limit", i_arready, LIM ? 0 : 1);
    for (int b = 0; b < 4; b++) begin
      o_rvalid = 1'b1; i_rready = 1'b1; o_rlast = (b == 3);
      o_rch = 8'h70 + 8'(b);
      cyc();
      chk("rd_beat_arready", i_arready, (!LIM || b == 3) ? 1 : 0);
      chk("r_pass", i_rch, 8'h70 + 8'(b));
    end
    o_rlast = 1'b1;
    cyc();
    {o_rvalid, i_rready, o_rlast} = '0;
    chk("rd_cleared", i_arready, 1);

    // Reset with three buffered requests
    o_awready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      i_awvalid = 1'b1; i_awch = 16'h4000 | 16'(k);
      cyc();
    end
    i_awvalid = 1'b0;
    chk("buffered_valid", o_awvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("arst_awvalid", o_awvalid, 0);
    chk("arst_awready", i_awready, 1);
    i_wvalid = 1'b1; i_wch = 8'h5A;
    #1;
    chk("arst_wvalid", o_wvalid, 1);
    chk("arst_wch", o_wch, 8'h5A);
    cyc();
    aresetn = 1'b1;
    i_wvalid = 1'b0;
    cyc();
    chk("post_arst_awvalid", o_awvalid, 0);

    // Random traffic on every channel, checked by the model
    for (int k = 0; k < 60; k++) begin
      i_awvalid = 1'($urandom); o_awready = 1'($urandom); i_awch = 16'($urandom);
      i_arvalid = 1'($urandom); o_arready = 1'($urandom); i_arch = 16'($urandom);
      i_wvalid = 1'($urandom); i_wlast = 1'($urandom); o_wready = 1'($urandom);
      i_wch = 8'($urandom);
      o_bvalid = 1'($urandom); i_bready = 1'($urandom); o_bch = 8'($urandom);
      o_rvalid = 1'($urandom); i_rready = 1'($urandom); o_rlast = 1'($urandom);
      o_rch = 8'($urandom);
      cyc();
    end
    {i_awvalid, i_arvalid, i_wvalid, o_bvalid, o_rvalid} = '0;
    o_awready = 1'b1; o_arready = 1'b1;
    repeat (6) cyc();
    chk("end_awempty", o_awvalid, 0);
    chk("end_arempty", o_arvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
